// File: rtl/match_pkg.sv
// Shared definitions for the best-of-N match sequencer: state encoding,
// winning game score, side codes and a saturating tally increment.
package match_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PLAY  = 3'd2,
        S_SCORE = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] WIN_SCORE  = 2'b11;
    localparam logic       SIDE_LEFT  = 1'b1;
    localparam logic       SIDE_RIGHT = 1'b0;

    function automatic logic [3:0] sat_inc(input logic [3:0] val);
        return (val == 4'hF) ? 4'hF : val + 4'd1;
    endfunction

endpackage

// File: rtl/match_timer.sv
// Loadable down-counter; o_done flags terminal count (zero). Used for the
// player-reset hold and the inter-game pause.
module match_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_count,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/match_controller.sv
// Best-of-N match sequencer around the single-game player block: arms each
// game, gates the paddle buttons, tallies game wins and declares the winner.
//
// state | meaning
// IDLE  | after reset, player held in reset, waiting for start
// ARM   | player held in reset for RST_CYCLES
// PLAY  | game running, buttons passed through
// SCORE | one cycle: judge the finished game
// PAUSE | scores visible, buttons blocked for PAUSE_CYCLES
// DONE  | match decided, waiting for start
module match_controller
    import match_pkg::*;
#(
    parameter int GAMES_TO_WIN = 3,
    parameter int RST_CYCLES   = 4,
    parameter int PAUSE_CYCLES = 100_000_000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_left_btn,
    input  logic       i_right_btn,
    input  logic       i_gamestate,
    input  logic [1:0] i_leftpscore,
    input  logic [1:0] i_rightpscore,
    output logic       o_game_rst_n,
    output logic       o_leftplayer,
    output logic       o_rightplayer,
    output logic [3:0] o_left_games,
    output logic [3:0] o_right_games,
    output logic       o_match_over,
    output logic       o_match_winner
);

    localparam int               ARM_W      = $clog2(RST_CYCLES + 1);
    localparam int               PAUSE_W    = $clog2(PAUSE_CYCLES + 1);
    // Timers load N-1 so the state lasts N cycles including the done cycle.
    localparam logic [ARM_W-1:0]   ARM_LOAD   = ARM_W'(RST_CYCLES - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [3:0]       WIN_GAMES  = 4'(GAMES_TO_WIN);

    state_t     r_state, w_next;
    logic       r_start_q, r_gs_q, r_seen_active;
    logic [3:0] r_left_games, r_right_games;
    logic       r_match_over, r_match_winner;
    logic       r_game_rst_n, r_leftplayer, r_rightplayer;

    logic       w_start_rise, w_fall;
    logic       w_arm_load, w_arm_done, w_pause_load, w_pause_done;
    logic       w_clear, w_left_inc, w_right_inc;
    logic [3:0] w_left_next, w_right_next;

    assign w_start_rise = i_start & ~r_start_q;
    assign w_fall       = r_gs_q & ~i_gamestate;
    assign w_left_next  = sat_inc(r_left_games);
    assign w_right_next = sat_inc(r_right_games);

    match_timer #(.WIDTH(ARM_W)) u_arm_timer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_arm_load),
        .i_load_val (ARM_LOAD),
        .i_count    (r_state == S_ARM),
        .o_done     (w_arm_done)
    );

    match_timer #(.WIDTH(PAUSE_W)) u_pause_timer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_pause_load),
        .i_load_val (PAUSE_LOAD),
        .i_count    (r_state == S_PAUSE),
        .o_done     (w_pause_done)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_arm_load   = 1'b0;
        w_pause_load = 1'b0;
        w_clear      = 1'b0;
        w_left_inc   = 1'b0;
        w_right_inc  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_rise) begin
                    w_clear    = 1'b1;
                    w_arm_load = 1'b1;
                    w_next     = S_ARM;
                end
            end
            S_ARM: begin
                if (w_arm_done) w_next = S_PLAY;
            end
            S_PLAY: begin
                if (w_fall && r_seen_active) w_next = S_SCORE;
            end
            S_SCORE: begin
                if (i_leftpscore == WIN_SCORE)       w_left_inc  = 1'b1;
                else if (i_rightpscore == WIN_SCORE) w_right_inc = 1'b1;
                if ((w_left_inc && (w_left_next >= WIN_GAMES)) ||
                    (w_right_inc && (w_right_next >= WIN_GAMES))) begin
                    w_next = S_DONE;
                end else begin
                    w_pause_load = 1'b1;
                    w_next       = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_pause_done) begin
                    w_arm_load = 1'b1;
                    w_next     = S_ARM;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_start_q      <= 1'b0;
            r_gs_q         <= 1'b0;
            r_seen_active  <= 1'b0;
            r_left_games   <= 4'd0;
            r_right_games  <= 4'd0;
            r_match_over   <= 1'b0;
            r_match_winner <= SIDE_RIGHT;
            r_game_rst_n   <= 1'b0;
            r_leftplayer   <= 1'b0;
            r_rightplayer  <= 1'b0;
        end else begin
            r_start_q     <= i_start;
            r_gs_q        <= i_gamestate;
            r_game_rst_n  <= (w_next != S_IDLE) && (w_next != S_ARM);
            r_leftplayer  <= i_left_btn  & (w_next == S_PLAY);
            r_rightplayer <= i_right_btn & (w_next == S_PLAY);

            if (r_state != S_PLAY) r_seen_active <= 1'b0;
            else if (i_gamestate)  r_seen_active <= 1'b1;

            if (w_clear) begin
                r_left_games  <= 4'd0;
                r_right_games <= 4'd0;
                r_match_over  <= 1'b0;
            end else begin
                if (w_left_inc)  r_left_games  <= w_left_next;
                if (w_right_inc) r_right_games <= w_right_next;
                if (w_next == S_DONE && r_state == S_SCORE) begin
                    r_match_over   <= 1'b1;
                    r_match_winner <= w_left_inc ? SIDE_LEFT : SIDE_RIGHT;
                end
            end
        end
    end

    assign o_game_rst_n   = r_game_rst_n;
    assign o_leftplayer   = r_leftplayer;
    assign o_rightplayer  = r_rightplayer;
    assign o_left_games   = r_left_games;
    assign o_right_games  = r_right_games;
    assign o_match_over   = r_match_over;
    assign o_match_winner = r_match_winner;

endmodule
